ram_scan_reader: RTL

- Read-side initiator for the 16x8 synchronous RAM (ce/we/addr/data_w/data_r, registered read address).
- On a start pulse, reads `count` consecutive bytes beginning at `base_addr`, wrapping mod 16.
- Delivers each byte on a valid/ready byte stream, e.g. to the LCD character writer.
- Never writes the RAM; it is the reader for the RAM's writer-side users.

---
 rtl/ram_if_pkg.sv | 19 +
 rtl/ram_16x8.sv | 33 +++
 rtl/ram_scan_reader.sv | 96 +++++++++
 3 files changed

// File: rtl/ram_if_pkg.sv
// Shared constants and state encoding for the 16x8 synchronous RAM and its
// read-side scan initiator.
package ram_if_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 16;
    localparam int CNT_W     = 5;

    // Scan FSM: request the RAM, wait one cycle for the registered read,
    // then hold the byte on the output stream until it is accepted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        SEND = 2'd3
    } scan_state_t;

endpackage : ram_if_pkg

// File: rtl/ram_16x8.sv
// 16x8 synchronous RAM with a registered read address: the address is
// captured on a clock edge with ce high, and data_r shows that word during
// the following cycle.
module ram_16x8 #(
    parameter int ADDR_W = ram_if_pkg::ADDR_W,
    parameter int DATA_W = ram_if_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_w,
    output logic [DATA_W-1:0] data_r
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;

    // Capture the read address and perform writes on enabled edges.
    always_ff @(posedge clk) begin
        if (ce) begin
            addr_q <= addr;
            if (we) begin
                mem[addr] <= data_w;
            end
        end
    end

    assign data_r = mem[addr_q];

endmodule : ram_16x8

// File: rtl/ram_scan_reader.sv
// Read-side initiator for the 16x8 RAM: on start, reads count consecutive
// bytes from base_addr (wrapping mod 16) and delivers them one at a time on
// a valid/ready byte stream.
//
// Stream handshake: a byte transfers on a rising edge where out_valid and
// out_ready are both high. Once raised, out_valid and out_data stay stable
// until that edge; out_ready may be high at any time and has no effect while
// out_valid is low.
module ram_scan_reader #(
    parameter int ADDR_W = ram_if_pkg::ADDR_W,
    parameter int DATA_W = ram_if_pkg::DATA_W,
    parameter int CNT_W  = ram_if_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data_r,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    import ram_if_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

    scan_state_t      state;
    logic [CNT_W-1:0] rem;   // bytes still to deliver after the current one

    // ram_addr doubles as the scan address register, so it already holds
    // the right address for the whole REQ cycle.
    assign busy   = (state != IDLE);
    assign ram_ce = (state == REQ);
    assign ram_we = 1'b0;

    // Scan sequencer with its address, count and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_addr  <= '0;
            rem       <= '0;
            done      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            ram_addr <= base_addr;
                            rem      <= count - CNT_ONE;
                            state    <= REQ;
                        end else begin
                            // Empty scan completes at once without touching the RAM.
                            done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    state <= LAT;
                end
                LAT: begin
                    out_data  <= ram_data_r;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rem == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ram_addr <= ram_addr + ADDR_ONE;
                            rem      <= rem - CNT_ONE;
                            state    <= REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : ram_scan_reader
